// File: rtl/pll_lock_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pll_seq_pkg
// Description : Shared types and helpers for the PLL lock / reset sequencer.
//               - state_t   : sequencer state encoding
//               - cnt_width : width of the single shared phase counter, wide
//                             enough to hold the largest terminal count
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_CORE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  // $clog2 of the largest cycle parameter, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop single-bit synchronizer, reset value 0. General
//               purpose; any single-bit level crossing into a clock domain.
// Ports       : i_clk   - destination clock
//               i_rst_n - asynchronous active-low reset
//               i_d     - asynchronous input level
//               o_q     - synchronized level (2-3 destination edges latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_seq
// Description : Controls the system PLL reset, waits for a stable lock and
//               then releases core and peripheral resets in order. Loss of
//               lock re-asserts the resets and restarts the PLL. Runs on the
//               free-running reference clock, never on a PLL output.
// Ports       : clk_sys       in  reference clock (same net as PLL refclk)
//               reset_n       in  asynchronous active-low reset
//               pll_locked    in  PLL lock indicator, asynchronous
//               soft_rst      in  1-cycle request to replay core/periph release
//               pll_rst       out PLL reset, active high
//               core_rst_n    out core reset, active low
//               periph_rst_n  out peripheral reset, active low
//               ready         out high only while running
//               lock_lost_cnt out lock losses after release, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYC     = 16,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP       = 64,
  parameter int RELOCK_TIMEOUT  = 1048576
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam int c_CNT_W = cnt_width(PLL_RST_CYC, LOCK_STABLE_CYC, STAGE_GAP, RELOCK_TIMEOUT);

  localparam logic [c_CNT_W-1:0] c_PLL_RST_LAST = c_CNT_W'(PLL_RST_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(STAGE_GAP - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(RELOCK_TIMEOUT - 1);

  logic               w_locked_s;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pll_rst;
  logic               r_core_rst_n;
  logic               r_periph_rst_n;
  logic               r_ready;
  logic [7:0]         r_lock_lost_cnt;

  sync_2ff u_lock_sync (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_locked_s)
  );

  // Outputs are assigned on the edge that changes state, so they are
  // registered and move together with r_state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= PLL_RST;
      r_cnt           <= '0;
      r_pll_rst       <= 1'b1;
      r_core_rst_n    <= 1'b0;
      r_periph_rst_n  <= 1'b0;
      r_ready         <= 1'b0;
      r_lock_lost_cnt <= 8'd0;
    end else begin
      // Counter holds in RUN (nothing is timed there); every transition
      // below overrides this with a clear.
      if (r_state != RUN) r_cnt <= r_cnt + 1'b1;

      case (r_state)
        PLL_RST: begin
          if (r_cnt == c_PLL_RST_LAST) begin
            r_state   <= WAIT_LOCK;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end
        end

        WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_state   <= PLL_RST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
          end
        end

        STABLE: begin
          // A dropout here only restarts the stability window; the PLL is
          // not reset and the loss counter is untouched.
          if (!w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_STABLE_LAST) begin
            r_state      <= REL_CORE;
            r_cnt        <= '0;
            r_core_rst_n <= 1'b1;
          end
        end

        REL_CORE, RUN: begin
          // Priority: lock loss, then soft reset, then normal progression.
          if (!w_locked_s) begin
            r_state        <= PLL_RST;
            r_cnt          <= '0;
            r_pll_rst      <= 1'b1;
            r_core_rst_n   <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_ready        <= 1'b0;
            if (r_lock_lost_cnt != 8'hFF) r_lock_lost_cnt <= r_lock_lost_cnt + 8'd1;
          end else if (soft_rst) begin
            r_state        <= STABLE;
            r_cnt          <= '0;
            r_core_rst_n   <= 1'b0;
            r_periph_rst_n <= 1'b0;
            r_ready        <= 1'b0;
          end else if ((r_state == REL_CORE) && (r_cnt == c_GAP_LAST)) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_periph_rst_n <= 1'b1;
            r_ready        <= 1'b1;
          end
        end

        default: begin
          r_state        <= PLL_RST;
          r_cnt          <= '0;
          r_pll_rst      <= 1'b1;
          r_core_rst_n   <= 1'b0;
          r_periph_rst_n <= 1'b0;
          r_ready        <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst       = r_pll_rst;
  assign core_rst_n    = r_core_rst_n;
  assign periph_rst_n  = r_periph_rst_n;
  assign ready         = r_ready;
  assign lock_lost_cnt = r_lock_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_reset_seq
// Description : Bench for pll_lock_reset_seq. Stimulus queues every expected
//               output change (value and clock-edge index); a monitor compares
//               each observed change against the head of the queue.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_reset_seq;

  logic       clk_sys;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       core_rst_n;
  logic       periph_rst_n;
  logic       ready;
  logic [7:0] lock_lost_cnt;

  wire logic [11:0] w_outs = {pll_rst, core_rst_n, periph_rst_n, ready, lock_lost_cnt};

  pll_lock_reset_seq #(
    .PLL_RST_CYC     (4),
    .LOCK_STABLE_CYC (8),
    .STAGE_GAP       (4),
    .RELOCK_TIMEOUT  (32)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .core_rst_n    (core_rst_n),
    .periph_rst_n  (periph_rst_n),
    .ready         (ready),
    .lock_lost_cnt (lock_lost_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [11:0] val;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic        mon_en   = 1'b0;
  logic [11:0] prev;
  int          lc = 0;   // expected lock_lost_cnt

  function automatic logic [11:0] ov(input logic pr, input logic c, input logic p,
                                     input logic r, input logic [7:0] n);
    return {pr, c, p, r, n};
  endfunction

  function automatic void push(input string nm, input logic [11:0] v, input int at);
    exp_t e;
    e.name = nm;
    e.val  = v;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  // Monitor: every change of the output vector must match the queue head.
  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (mon_en && (w_outs !== prev)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change: got %h at edge %0d, required no change", w_outs, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((w_outs !== e.val) || (cyc != e.at)) begin
          n_err++;
          $display("FAIL %s: got %h at edge %0d, required %h at edge %0d",
                   e.name, w_outs, cyc, e.val, e.at);
        end
      end
      prev = w_outs;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  task automatic drain(input string nm);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_pending: got %0d outstanding events (next %s), required 0",
               nm, exp_q.size(), exp_q[0].name);
      exp_q.delete();
    end
  endtask

  // From RUN: drop lock, optionally collide with soft_rst, relock, back to RUN.
  task automatic lose_relock(input bit with_soft);
    int l;
    l = cyc;
    pll_locked = 1'b0;
    if (lc != 255) lc++;
    push("loss_enter_pll_rst", ov(1, 0, 0, 0, 8'(lc)), l + 3);
    push("loss_pll_rst_fall",  ov(0, 0, 0, 0, 8'(lc)), l + 7);
    tick(2);
    if (with_soft) soft_rst = 1'b1;   // sampled on the same edge as the loss
    tick(1);
    soft_rst = 1'b0;
    tick(5);
    pll_locked = 1'b1;
    push("relock_core_up", ov(0, 1, 0, 0, 8'(lc)), l + 19);
    push("relock_run",     ov(0, 1, 1, 1, 8'(lc)), l + 23);
    tick(17);
  endtask

  initial begin : stim
    int r;
    int s;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;
    tick(3);
    check("reset_values", w_outs, ov(1, 0, 0, 0, 8'd0));
    prev   = w_outs;
    mon_en = 1'b1;

    // Initial bring-up, lock arrives 10 cycles after release.
    r = cyc;
    reset_n = 1'b1;
    push("p1_pll_rst_fall", ov(0, 0, 0, 0, 8'd0), r + 4);
    push("p1_core_up",      ov(0, 1, 0, 0, 8'd0), r + 21);
    push("p1_run",          ov(0, 1, 1, 1, 8'd0), r + 25);
    tick(10);
    pll_locked = 1'b1;
    tick(20);
    drain("p1");

    // Soft reset in RUN.
    s = cyc;
    soft_rst = 1'b1;
    push("p5_soft_drop", ov(0, 0, 0, 0, 8'd0), s + 1);
    push("p5_core_up",   ov(0, 1, 0, 0, 8'd0), s + 9);
    push("p5_run",       ov(0, 1, 1, 1, 8'd0), s + 13);
    tick(1);
    soft_rst = 1'b0;
    tick(15);
    drain("p5");

    // 3-cycle lock glitch while in STABLE; soft_rst in STABLE ignored.
    s = cyc;
    soft_rst = 1'b1;
    push("p2_soft_drop", ov(0, 0, 0, 0, 8'd0), s + 1);
    tick(1);
    soft_rst = 1'b0;
    tick(2);
    pll_locked = 1'b0;
    tick(3);
    pll_locked = 1'b1;
    push("p2_core_up", ov(0, 1, 0, 0, 8'd0), s + 17);
    push("p2_run",     ov(0, 1, 1, 1, 8'd0), s + 21);
    tick(4);
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    tick(15);
    drain("p2");

    // Lock loss in RUN, then loss colliding with soft_rst.
    lose_relock(1'b0);
    drain("p4_loss");
    lose_relock(1'b1);
    drain("p4_loss_soft");

    // Saturation: 260 losses in total.
    repeat (258) lose_relock(1'b0);
    drain("p6_sat");
    check("p6_cnt_saturated", {4'd0, lock_lost_cnt}, {4'd0, 8'd255});

    // Loss, relock, then reset_n asserted mid-REL_CORE.
    s = cyc;
    pll_locked = 1'b0;
    push("p6_loss",          ov(1, 0, 0, 0, 8'd255), s + 3);
    push("p6_pll_rst_fall",  ov(0, 0, 0, 0, 8'd255), s + 7);
    push("p6_core_up",       ov(0, 1, 0, 0, 8'd255), s + 19);
    push("p6_async_reset",   ov(1, 0, 0, 0, 8'd0),   s + 20);
    tick(8);
    pll_locked = 1'b1;
    tick(12);
    reset_n = 1'b0;
    #1;
    check("p6_async_reset_now", w_outs, ov(1, 0, 0, 0, 8'd0));
    lc = 0;
    tick(2);
    // Release with lock already present.
    r = cyc;
    reset_n = 1'b1;
    push("p6r_pll_rst_fall", ov(0, 0, 0, 0, 8'd0), r + 4);
    push("p6r_core_up",      ov(0, 1, 0, 0, 8'd0), r + 13);
    push("p6r_run",          ov(0, 1, 1, 1, 8'd0), r + 17);
    tick(20);
    drain("p6r");

    // Permanent unlock from a fresh reset: 4-high / 36-period pll_rst.
    s = cyc;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    push("p3_reset", ov(1, 0, 0, 0, 8'd0), s);
    tick(2);
    r = cyc;
    reset_n = 1'b1;
    push("p3_fall0", ov(0, 0, 0, 0, 8'd0), r + 4);
    push("p3_rise1", ov(1, 0, 0, 0, 8'd0), r + 36);
    push("p3_fall1", ov(0, 0, 0, 0, 8'd0), r + 40);
    push("p3_rise2", ov(1, 0, 0, 0, 8'd0), r + 72);
    push("p3_fall2", ov(0, 0, 0, 0, 8'd0), r + 76);
    tick(80);
    pll_locked = 1'b1;
    push("p3_core_up", ov(0, 1, 0, 0, 8'd0), r + 91);
    push("p3_run",     ov(0, 1, 1, 1, 8'd0), r + 95);
    tick(20);
    drain("p3");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
